// File: rtl/cam_emulator.sv
// -----------------------------------------------------------------------------
// cam_emulator
//
// Purpose:
//    Synthesizable stand-in for an OV7670-style sensor. It produces vsync,
//    href and an 8-bit data bus in RGB444 two-bytes-per-pixel format on the
//    pclk domain. The pixel content is deterministic, so a downstream checker
//    can recompute every expected pixel.
//
// Ports:
//    i_clk         in   1  pclk-domain clock (the only clock)
//    i_rstn        in   1  asynchronous active-low reset
//    i_en          in   1  run enable, level-sensitive (sampled in IDLE and
//                          at frame end only)
//    o_vsync       out  1  frame sync, active high
//    o_href        out  1  line valid, active high
//    o_data        out  8  pixel byte, 8'h00 whenever o_href is low
//    o_frame_done  out  1  one-clock pulse at end of frame
//    o_busy        out  1  high in every state except IDLE
//    o_frame_cnt   out  8  completed-frame count, wraps 255 -> 0
//
// Build option:
//    CAM_EMULATOR_PRBS_EN  when defined, pixels come from a 12-bit Fibonacci
//                          LFSR (x^12+x^6+x^4+x+1) reseeded at each vsync
//                          rise; otherwise P = (row + col + frame) mod 4096.
// -----------------------------------------------------------------------------
module cam_emulator #(
   parameter int ROWLENGTH     = 640,
   parameter int ROWCOUNT      = 480,
   parameter int VSYNC_CYCLES  = 4704,
   parameter int VBP_CYCLES    = 26656,
   parameter int HBLANK_CYCLES = 288
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_en,
   output logic       o_vsync,
   output logic       o_href,
   output logic [7:0] o_data,
   output logic       o_frame_done,
   output logic       o_busy,
   output logic [7:0] o_frame_cnt
);

   localparam int LINE_BYTES = 2 * ROWLENGTH;
   localparam int MAX_AB     = (VSYNC_CYCLES > VBP_CYCLES) ? VSYNC_CYCLES : VBP_CYCLES;
   localparam int MAX_CD     = (LINE_BYTES > HBLANK_CYCLES) ? LINE_BYTES : HBLANK_CYCLES;
   localparam int MAX_CYC    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   // The cycle counter holds (length-1) down to 0, so $clog2(max) bits suffice.
   localparam int CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int ROW_W      = (ROWCOUNT > 1) ? $clog2(ROWCOUNT) : 1;
   localparam int COL_W      = (ROWLENGTH > 1) ? $clog2(ROWLENGTH) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBP,
      ST_LINE,
      ST_HBLANK
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic               phase_q, phase_d;      // 0 = even (high nibble) byte
   logic [7:0]         frame_cnt_q, frame_cnt_d;
   logic               vsync_q, vsync_d;
   logic               href_q, href_d;
   logic [7:0]         data_q, data_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic [11:0]        pix_d;                 // pixel value for the next byte

   // -------------------------------------------------------------------------
   // Next-state and counter logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      col_d       = col_q;
      phase_d     = phase_q;
      frame_cnt_d = frame_cnt_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_en) begin
               state_d = ST_VSYNC;
               cnt_d   = CNT_W'(VSYNC_CYCLES - 1);
            end
         end

         ST_VSYNC: begin
            if (cnt_q == '0) begin
               state_d = ST_VBP;
               cnt_d   = CNT_W'(VBP_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_VBP: begin
            if (cnt_q == '0) begin
               state_d = ST_LINE;
               cnt_d   = CNT_W'(LINE_BYTES - 1);
               row_d   = '0;
               col_d   = '0;
               phase_d = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_LINE: begin
            phase_d = ~phase_q;
            // Column advances after the odd byte of each pixel.
            if (phase_q) begin
               col_d = col_q + COL_W'(1);
            end
            if (cnt_q == '0) begin
               state_d = ST_HBLANK;
               cnt_d   = CNT_W'(HBLANK_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_HBLANK: begin
            if (cnt_q == '0) begin
               if (row_q == ROW_W'(ROWCOUNT - 1)) begin
                  // Frame end: the only point besides IDLE where i_en matters.
                  done_d      = 1'b1;
                  frame_cnt_d = frame_cnt_q + 8'd1;
                  if (i_en) begin
                     state_d = ST_VSYNC;
                     cnt_d   = CNT_W'(VSYNC_CYCLES - 1);
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_LINE;
                  cnt_d   = CNT_W'(LINE_BYTES - 1);
                  row_d   = row_q + ROW_W'(1);
                  col_d   = '0;
                  phase_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Pixel source
   // -------------------------------------------------------------------------
`ifdef CAM_EMULATOR_PRBS_EN
   logic [11:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      // Step once per pixel, after its odd byte has been presented.
      if (state_q == ST_LINE && phase_q) begin
         lfsr_d = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
      end
      // Reseed on vsync rise using the count of the frame about to start.
      if (state_d == ST_VSYNC && state_q != ST_VSYNC) begin
         lfsr_d = 12'hACE ^ {4'h0, frame_cnt_d};
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         lfsr_q <= 12'hACE;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign pix_d = lfsr_d;
`else
   // frame_cnt_q is constant for the whole frame, so it is the frame index.
   assign pix_d = 12'(row_d) + 12'(col_d) + 12'(frame_cnt_q);
`endif

   // -------------------------------------------------------------------------
   // Registered outputs, derived from the next state so they align with it
   // -------------------------------------------------------------------------
   always_comb begin
      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_LINE);
      busy_d  = (state_d != ST_IDLE);
      data_d  = 8'h00;
      if (state_d == ST_LINE) begin
         data_d = phase_d ? pix_d[7:0] : {4'hF, pix_d[11:8]};
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         phase_q     <= 1'b0;
         frame_cnt_q <= 8'd0;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         data_q      <= 8'h00;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         col_q       <= col_d;
         phase_q     <= phase_d;
         frame_cnt_q <= frame_cnt_d;
         vsync_q     <= vsync_d;
         href_q      <= href_d;
         data_q      <= data_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign o_vsync      = vsync_q;
   assign o_href       = href_q;
   assign o_data       = data_q;
   assign o_frame_done = done_q;
   assign o_busy       = busy_q;
   assign o_frame_cnt  = frame_cnt_q;

endmodule
